// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared widths, FSM encoding and request types for the register bus arbiter
package reg_bus_pkg;

   localparam int AW_DEF = 15;
   localparam int DW_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   localparam logic REQ_WR = 1'b0;
   localparam logic REQ_RD = 1'b1;

endpackage

// File: rtl/reg_bus_req_slot.sv
// rtl/reg_bus_req_slot.sv - one-deep request holding slot with sticky overflow flag
module reg_bus_req_slot import reg_bus_pkg::*; #(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          wr_en,
   input  logic          rd_en,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   input  logic          grant,
   output logic          pending,
   output logic [AW-1:0] req_addr,
   output logic [DW-1:0] req_wdata,
   output logic          req_type,
   output logic          ovf
);

   logic pulse;
   assign pulse = wr_en | rd_en;

   // Capture a new request when the slot is free or being emptied this cycle; a new pulse beats the grant clear
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pending   <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_type  <= REQ_WR;
         ovf       <= 1'b0;
      end else begin
         if (pulse && (!pending || grant)) begin
            pending   <= 1'b1;
            req_addr  <= addr;
            req_wdata <= wdata;
            req_type  <= wr_en ? REQ_WR : REQ_RD;
         end else if (grant) begin
            pending   <= 1'b0;
         end
         // Simultaneous wr+rd loses the read; a pulse into an occupied, ungranted slot is lost entirely
         if ((wr_en && rd_en) || (pulse && pending && !grant))
            ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin sharing of the system register bus between SPI bridge and local host
module reg_bus_arbiter import reg_bus_pkg::*; #(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int RD_LATENCY = 2
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          m0_wr_en,
   input  logic          m0_rd_en,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_rvalid,
   output logic          m0_ovf,
   input  logic          m1_wr_en,
   input  logic          m1_rd_en,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_rvalid,
   output logic          m1_ovf,
   output logic          bus_wr_en,
   output logic          bus_rd_en,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   output logic          busy
);

   localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);

   state_t        state;
   logic          last_grant;
   logic          gnt_id;
   logic [2:0]    lat_cnt;

   logic [1:0]    pend;
   logic [1:0]    grant;
   logic [AW-1:0] a0, a1;
   logic [DW-1:0] w0, w1;
   logic          t0, t1;
   logic          win;
   logic          any_pend;

   reg_bus_req_slot #(.AW(AW), .DW(DW)) u_slot0 (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .wr_en(m0_wr_en), .rd_en(m0_rd_en), .addr(m0_addr), .wdata(m0_wdata),
      .grant(grant[0]), .pending(pend[0]),
      .req_addr(a0), .req_wdata(w0), .req_type(t0), .ovf(m0_ovf)
   );

   reg_bus_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .wr_en(m1_wr_en), .rd_en(m1_rd_en), .addr(m1_addr), .wdata(m1_wdata),
      .grant(grant[1]), .pending(pend[1]),
      .req_addr(a1), .req_wdata(w1), .req_type(t1), .ovf(m1_ovf)
   );

   assign any_pend = pend[0] | pend[1];

   // Round-robin pick: a lone pending slot wins, on a tie the one not granted last time wins
   always_comb begin
      win = 1'b0;
      if (pend[0] && pend[1])
         win = ~last_grant;
      else if (pend[1])
         win = 1'b1;
   end

   assign grant[0] = (state == ST_IDLE) && any_pend && !win;
   assign grant[1] = (state == ST_IDLE) && any_pend &&  win;
   assign busy     = (state != ST_IDLE) || any_pend;

   // Bus sequencer: one transaction in flight, read data routed back to whoever was granted
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         gnt_id     <= 1'b0;
         lat_cnt    <= 3'd0;
         bus_wr_en  <= 1'b0;
         bus_rd_en  <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
         m0_rvalid  <= 1'b0;
         m1_rvalid  <= 1'b0;
      end else begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_pend) begin
                  bus_addr   <= win ? a1 : a0;
                  bus_wdata  <= win ? w1 : w0;
                  last_grant <= win;
                  gnt_id     <= win;
                  if ((win ? t1 : t0) == REQ_WR) begin
                     bus_wr_en <= 1'b1;
                     state     <= ST_WR;
                  end else begin
                     bus_rd_en <= 1'b1;
                     state     <= ST_RD;
                  end
               end
            end
            ST_WR: begin
               bus_wr_en <= 1'b0;
               state     <= ST_IDLE;
            end
            ST_RD: begin
               bus_rd_en <= 1'b0;
               lat_cnt   <= LAT_LOAD;
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               if (lat_cnt == 3'd0) begin
                  if (gnt_id) begin
                     m1_rdata  <= bus_rdata;
                     m1_rvalid <= 1'b1;
                  end else begin
                     m0_rdata  <= bus_rdata;
                     m0_rvalid <= 1'b1;
                  end
                  state <= ST_IDLE;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
